// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the memory-game sequence presenter: state encodings
// (also read by the db_estado hex decoder) and default phase durations.
package exibe_sequencia_pkg;

    typedef enum logic [3:0] {
        Ocioso  = 4'd0,
        Carrega = 4'd1,
        Le      = 4'd2,
        Aceso   = 4'd3,
        Apagado = 4'd4,
        Fim     = 4'd5
    } estado_e;

    localparam int unsigned TAcesoPadrao   = 1000;
    localparam int unsigned TApagadoPadrao = 500;

    // Bits needed to hold the longer of the two phase durations.
    function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// Loadable down-counter; fim_o marks the last cycle of a loaded interval,
// so a phase loaded with N lasts exactly N cycles.
module temporizador #(
    parameter int unsigned Largura = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               carrega_i,
    input  logic [Largura-1:0] valor_i,
    output logic               fim_o
);

    logic [Largura-1:0] conta_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            conta_q <= '0;
        end else if (carrega_i) begin
            conta_q <= valor_i;
        end else if (conta_q != '0) begin
            conta_q <= conta_q - 1'b1;
        end
    end

    assign fim_o = (conta_q == Largura'(1));

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter: walks ROM addresses 0..limit, showing each entry on the
// LEDs for T_ACESO cycles followed by T_APAGADO dark cycles.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int unsigned T_ACESO   = TAcesoPadrao,
    parameter int unsigned T_APAGADO = TApagadoPadrao
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned TW = largura_timer(T_ACESO, T_APAGADO);

    estado_e       estado_q;
    logic [3:0]    endereco_q;
    logic [3:0]    limite_q;
    logic [3:0]    leds_q;
    logic          ocupado_q;
    logic          pronto_q;

    logic          timer_carga;
    logic [TW-1:0] timer_valor;
    logic          timer_fim;

    // The timer is loaded on entry to each timed phase: from LE for the lit
    // phase, and at lit-phase expiry for the dark phase.
    always_comb begin
        timer_carga = (estado_q == Le) || ((estado_q == Aceso) && timer_fim);
        timer_valor = (estado_q == Le) ? TW'(T_ACESO) : TW'(T_APAGADO);
    end

    temporizador #(
        .Largura (TW)
    ) u_temporizador (
        .clock_i   (clock),
        .reset_i   (reset),
        .carrega_i (timer_carga),
        .valor_i   (timer_valor),
        .fim_o     (timer_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= Ocioso;
            endereco_q <= 4'd0;
            limite_q   <= 4'd0;
            leds_q     <= 4'd0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            unique case (estado_q)
                Ocioso: begin
                    if (iniciar) begin
                        limite_q   <= limite;
                        endereco_q <= 4'd0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= Carrega;
                    end
                end
                Carrega: estado_q <= Le;
                Le: begin
                    leds_q   <= dado;
                    estado_q <= Aceso;
                end
                Aceso: begin
                    if (timer_fim) begin
                        leds_q   <= 4'd0;
                        estado_q <= Apagado;
                    end
                end
                Apagado: begin
                    if (timer_fim) begin
                        // Compare before incrementing so limit 15 never wraps.
                        if (endereco_q == limite_q) begin
                            pronto_q <= 1'b1;
                            estado_q <= Fim;
                        end else begin
                            endereco_q <= endereco_q + 4'd1;
                            estado_q   <= Carrega;
                        end
                    end
                end
                Fim: begin
                    endereco_q <= 4'd0;
                    ocupado_q  <= 1'b0;
                    estado_q   <= Ocioso;
                end
                default: estado_q <= Ocioso;
            endcase
        end
    end

    assign endereco  = endereco_q;
    assign leds      = leds_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule
